// File: rtl/sm_trace_buffer.sv
// sm_trace_buffer: arm-triggered instruction trace capture (fill-once, PC trigger plus post-count, timeout).
// Read data is registered one cycle after rd_addr; no backpressure, retiring instructions are never stalled.
module sm_trace_buffer #(
  parameter int DEPTH   = 16,
  parameter int AW      = 4,
  parameter int POST    = 4,
  parameter int TIMEOUT = 120
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic [31:0]   pc,
  input  logic [31:0]   instr,
  input  logic [1:0]    mode,
  input  logic [31:0]   trig_pc,
  input  logic          arm,
  input  logic          stop,
  input  logic [AW-1:0] rd_addr,
  output logic [31:0]   rd_pc,
  output logic [31:0]   rd_instr,
  output logic [AW:0]   count,
  output logic [31:0]   cycle,
  output logic [1:0]    state,
  output logic          done,
  output logic          timeout
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_POST  = 2'd2,
    S_DONE  = 2'd3
  } stateT;

  localparam logic [AW:0]   FULL  = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] POSTV = AW'(POST);
  localparam logic [31:0]   TLAST = 32'(TIMEOUT - 1);

  stateT         stateQ;
  logic [1:0]    modeQ;
  logic [AW-1:0] wrPtr;
  logic [AW-1:0] postCnt;
  logic [AW-1:0] rdIdx;
  logic [63:0]   mem [DEPTH];

  logic active;
  logic doWrite;
  logic fillMode;
  logic trigHit;
  logic timeHit;

  assign active   = (stateQ == S_ARMED) || (stateQ == S_POST);
  assign doWrite  = active && !stop && en;
  assign fillMode = (modeQ == 2'd0) || (modeQ == 2'd3);
  assign trigHit  = (modeQ == 2'd1) && (stateQ == S_ARMED) && (pc == trig_pc);
  assign timeHit  = (modeQ == 2'd2) && (cycle == TLAST);
  assign state    = stateQ;

  // Once the buffer has wrapped, wrPtr points at the oldest entry.
  assign rdIdx = ((count == FULL) ? wrPtr : '0) + rd_addr;

  always_ff @(posedge clk) begin
    if (doWrite) begin
      mem[wrPtr] <= {pc, instr};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pc    <= '0;
      rd_instr <= '0;
    end else begin
      rd_pc    <= mem[rdIdx][63:32];
      rd_instr <= mem[rdIdx][31:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateQ  <= S_IDLE;
      modeQ   <= '0;
      wrPtr   <= '0;
      postCnt <= '0;
      count   <= '0;
      cycle   <= '0;
      done    <= 1'b0;
      timeout <= 1'b0;
    end else if (!active) begin
      if (arm) begin
        stateQ  <= S_ARMED;
        modeQ   <= mode;
        wrPtr   <= '0;
        postCnt <= '0;
        count   <= '0;
        cycle   <= '0;
        done    <= 1'b0;
        timeout <= 1'b0;
      end
    end else begin
      cycle <= cycle + 32'd1;
      if (stop) begin
        stateQ <= S_DONE;
        done   <= 1'b1;
      end else begin
        if (en) begin
          wrPtr <= wrPtr + AW'(1);
          if (count != FULL) begin
            count <= count + (AW+1)'(1);
          end
        end
        // The timeout write above still lands; the state change wins over trigger logic.
        if (timeHit) begin
          timeout <= 1'b1;
          stateQ  <= S_DONE;
          done    <= 1'b1;
        end else if (en) begin
          if (fillMode && (count == FULL - (AW+1)'(1))) begin
            stateQ <= S_DONE;
            done   <= 1'b1;
          end else if (trigHit) begin
            if (POST == 0) begin
              stateQ <= S_DONE;
              done   <= 1'b1;
            end else begin
              stateQ  <= S_POST;
              postCnt <= POSTV;
            end
          end else if (stateQ == S_POST) begin
            postCnt <= postCnt - AW'(1);
            if (postCnt == AW'(1)) begin
              stateQ <= S_DONE;
              done   <= 1'b1;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_sm_trace_buffer.sv
// Directed bench for sm_trace_buffer with a queue-based reference model checked every cycle.
module tb_sm_trace_buffer;
  localparam int DEPTH   = 16;
  localparam int AW      = 4;
  localparam int POST    = 4;
  localparam int TIMEOUT = 120;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic [31:0]   pc;
  logic [31:0]   instr;
  logic [1:0]    mode;
  logic [31:0]   trig_pc;
  logic          arm;
  logic          stop;
  logic [AW-1:0] rd_addr;
  logic [31:0]   rd_pc;
  logic [31:0]   rd_instr;
  logic [AW:0]   count;
  logic [31:0]   cycle;
  logic [1:0]    state;
  logic          done;
  logic          timeout;

  always #5 clk = ~clk;

  sm_trace_buffer #(.DEPTH(DEPTH), .AW(AW), .POST(POST), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .pc(pc), .instr(instr), .mode(mode),
    .trig_pc(trig_pc), .arm(arm), .stop(stop), .rd_addr(rd_addr),
    .rd_pc(rd_pc), .rd_instr(rd_instr), .count(count), .cycle(cycle),
    .state(state), .done(done), .timeout(timeout)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: entries since arm, oldest first, at most DEPTH kept.
  logic [63:0] mq[$];
  int          mState;
  logic [1:0]  mMode;
  logic [31:0] mCycle;
  logic        mTimeout;
  int          mPostLeft;

  function automatic logic [31:0] instrOf(input logic [31:0] p);
    return p ^ 32'h5A5A_F00F;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic modelReset();
    mq.delete();
    mState    = 0;
    mMode     = 2'd0;
    mCycle    = 32'd0;
    mTimeout  = 1'b0;
    mPostLeft = 0;
  endtask

  task automatic step();
    logic        rdValid;
    logic [63:0] rdExp;
    rdValid = int'(rd_addr) < mq.size();
    rdExp   = rdValid ? mq[rd_addr] : 64'd0;
    if (mState == 0 || mState == 3) begin
      if (arm) begin
        mq.delete();
        mCycle    = 32'd0;
        mTimeout  = 1'b0;
        mMode     = mode;
        mPostLeft = 0;
        mState    = 1;
      end
    end else begin
      mCycle = mCycle + 32'd1;
      if (stop) begin
        mState = 3;
      end else begin
        if (en) begin
          mq.push_back({pc, instr});
          if (mq.size() > DEPTH) void'(mq.pop_front());
        end
        if (mMode == 2'd2 && mCycle == 32'(TIMEOUT)) begin
          mTimeout = 1'b1;
          mState   = 3;
        end else if (en) begin
          if (mMode == 2'd0 || mMode == 2'd3) begin
            if (mq.size() == DEPTH) mState = 3;
          end else if (mMode == 2'd1) begin
            if (mState == 1 && pc == trig_pc) begin
              if (POST == 0) mState = 3;
              else begin
                mState    = 2;
                mPostLeft = POST;
              end
            end else if (mState == 2) begin
              mPostLeft--;
              if (mPostLeft == 0) mState = 3;
            end
          end
        end
      end
    end
    @(posedge clk);
    #1;
    check("state", 64'(state), 64'(mState));
    check("count", 64'(count), 64'(mq.size()));
    check("cycle", 64'(cycle), 64'(mCycle));
    check("done", 64'(done), 64'(mState == 3));
    check("timeout", 64'(timeout), 64'(mTimeout));
    if (rdValid) check("rd_data", {rd_pc, rd_instr}, rdExp);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; en = 1'b0; pc = '0; instr = '0; mode = 2'd0;
    trig_pc = '0; arm = 1'b0; stop = 1'b0; rd_addr = '0;
    modelReset();
    #2;
    check("rst_state", 64'(state), 64'd0);
    check("rst_count", 64'(count), 64'd0);
    check("rst_cycle", 64'(cycle), 64'd0);
    check("rst_flags", {62'd0, done, timeout}, 64'd0);
    check("rst_rd", {rd_pc, rd_instr}, 64'd0);
    #2 rst_n = 1'b1;

    // Fill-once: arm-cycle write suppressed, later mode change ignored.
    mode = 2'd0; arm = 1'b1; en = 1'b1; pc = 32'd999; instr = instrOf(32'd999);
    step();
    arm = 1'b0;
    check("s1_armed", 64'(state), 64'd1);
    check("s1_arm_nowrite", 64'(count), 64'd0);
    trig_pc = 32'd5;
    for (int i = 0; i < 20; i++) begin
      pc = 32'(i); instr = instrOf(32'(i)); en = 1'b1;
      mode = (i >= 3) ? 2'd1 : 2'd0;
      rd_addr = AW'(i);
      step();
      if (i == 14) check("s1_not_done15", 64'(state), 64'd1);
      if (i == 15) check("s1_done16", 64'(state), 64'd3);
    end
    en = 1'b0;
    check("s1_count", 64'(count), 64'd16);
    for (int i = 0; i < 16; i++) begin
      rd_addr = AW'(i);
      step();
      check("s1_rd_pc", 64'(rd_pc), 64'(i));
    end

    // Timeout mode, with an arm pulse while ARMED that must be ignored.
    mode = 2'd2; arm = 1'b1; en = 1'b0;
    step();
    for (int i = 0; i < 130; i++) begin
      pc = 32'(i); instr = instrOf(32'(i)); en = 1'b1; rd_addr = '0;
      arm  = (i == 50);
      mode = (i == 50) ? 2'd0 : 2'd2;
      step();
    end
    arm = 1'b0; en = 1'b0;
    check("s2_timeout", 64'(timeout), 64'd1);
    check("s2_state", 64'(state), 64'd3);
    check("s2_cycle", 64'(cycle), 64'd120);
    check("s2_count", 64'(count), 64'd16);
    rd_addr = '0;
    step();
    check("s2_oldest", 64'(rd_pc), 64'd104);
    rd_addr = 4'd15;
    step();
    check("s2_newest", 64'(rd_pc), 64'd119);

    // PC trigger with post-capture.
    mode = 2'd1; trig_pc = 32'd10; arm = 1'b1;
    step();
    arm = 1'b0;
    check("s3_tmo_clr", 64'(timeout), 64'd0);
    for (int i = 0; i <= 30; i++) begin
      pc = 32'(i); instr = instrOf(32'(i)); en = 1'b1; rd_addr = AW'(i);
      step();
      if (i == 13) check("s3_post", 64'(state), 64'd2);
      if (i == 14) check("s3_done", 64'(state), 64'd3);
    end
    en = 1'b0;
    check("s3_count", 64'(count), 64'd15);
    rd_addr = '0;
    step();
    check("s3_rd0", 64'(rd_pc), 64'd0);
    rd_addr = 4'd14;
    step();
    check("s3_rd14", 64'(rd_pc), 64'd14);

    // Re-arm from DONE, then stop beating a simultaneous write and trigger.
    trig_pc = 32'd50; arm = 1'b1;
    step();
    arm = 1'b0;
    check("s4_count0", 64'(count), 64'd0);
    check("s4_cycle0", 64'(cycle), 64'd0);
    check("s4_armed", 64'(state), 64'd1);
    for (int i = 40; i < 42; i++) begin
      pc = 32'(i); instr = instrOf(32'(i)); en = 1'b1; rd_addr = '0;
      step();
    end
    pc = 32'd50; instr = instrOf(32'd50); stop = 1'b1;
    step();
    check("s4_stop_done", 64'(state), 64'd3);
    check("s4_stop_count", 64'(count), 64'd2);
    step();
    stop = 1'b0; en = 1'b0;
    rd_addr = 4'd1;
    step();
    check("s4_rd1", 64'(rd_pc), 64'd41);

    // Asynchronous reset in the middle of POST.
    trig_pc = 32'd7; arm = 1'b1;
    step();
    arm = 1'b0;
    for (int i = 5; i < 10; i++) begin
      pc = 32'(i); instr = instrOf(32'(i)); en = 1'b1;
      step();
    end
    en = 1'b0;
    check("s5_in_post", 64'(state), 64'd2);
    #3 rst_n = 1'b0;
    #1;
    modelReset();
    check("s5_rst_state", 64'(state), 64'd0);
    check("s5_rst_count", 64'(count), 64'd0);
    check("s5_rst_cycle", 64'(cycle), 64'd0);
    check("s5_rst_done", 64'(done), 64'd0);
    check("s5_rst_rd", 64'(rd_pc), 64'd0);
    #2 rst_n = 1'b1;
    mode = 2'd3; arm = 1'b1;
    step();
    arm = 1'b0;
    check("s5_rearm", 64'(state), 64'd1);
    for (int i = 100; i < 104; i++) begin
      pc = 32'(i); instr = instrOf(32'(i)); en = 1'b1; rd_addr = '0;
      step();
    end
    en = 1'b0;
    check("s5_count", 64'(count), 64'd4);
    rd_addr = 4'd2;
    step();
    check("s5_rd2", 64'(rd_pc), 64'd102);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
